// File: rtl/ecc_wr_encoder_if.sv
// Write-path bundle between upstream producer, SECDED encoder and FIFO memory.
// master = producer/memory side, slave = encoder.
interface ecc_wr_encoder_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int MEMORY_DATA_WIDTH = 39
);
  logic                         wr_en_i;
  logic [DATA_WIDTH-1:0]        wr_data_i;
  logic                         wr_ready_o;
  logic                         mem_full_i;
  logic                         mem_wr_en_o;
  logic [MEMORY_DATA_WIDTH-1:0] mem_wr_data_o;

  modport master (
    output wr_en_i,
    output wr_data_i,
    output mem_full_i,
    input  wr_ready_o,
    input  mem_wr_en_o,
    input  mem_wr_data_o
  );

  modport slave (
    input  wr_en_i,
    input  wr_data_i,
    input  mem_full_i,
    output wr_ready_o,
    output mem_wr_en_o,
    output mem_wr_data_o
  );
endinterface

// File: rtl/ecc_wr_encoder.sv
// Write-side SECDED (Hamming(38,32)+overall parity) encoder, 2-stage stallable.
// Define ECC_ERR_INJ_EN to add the error-injection ports and logic.
module ecc_wr_encoder #(
  parameter int DATA_WIDTH        = 32,
  parameter int MEMORY_DATA_WIDTH = 39,
  parameter int PARITY_BITS       = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ECC_en,
  ecc_wr_encoder_if.slave       bus,
`ifdef ECC_ERR_INJ_EN
  input  logic                  inj_arm_i,
  input  logic [1:0]            inj_mode_i,
  input  logic [5:0]            inj_pos0_i,
  input  logic [5:0]            inj_pos1_i,
  output logic                  inj_done_o,
`endif
  output logic [31:0]           enc_count_o
);

  localparam int MW = MEMORY_DATA_WIDTH;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_ecc_q, s1_ecc_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [MW-1:0]         s2_data_q, s2_data_d;
  logic [31:0]           cnt_q, cnt_d;

  logic          s2_drain;
  logic          s1_move;
  logic          wr_ready;
  logic          accept;
  logic [MW-1:0] enc_word;
  logic [MW-1:0] flip_mask;

  logic unused_ecc_en;
  assign unused_ecc_en = ^ECC_en[DATA_WIDTH-1:1];

  assign s2_drain = s2_valid_q && !bus.mem_full_i;
  assign s1_move  = s1_valid_q && (!s2_valid_q || s2_drain);
  assign wr_ready = !s1_valid_q || s1_move;
  assign accept   = bus.wr_en_i && wr_ready;

  // Check bit k is the XOR of bit k of every set data position's index.
  always_comb begin
    logic [PARITY_BITS-1:0] syn;
    enc_word         = '0;
    syn              = '0;
    enc_word[38:33]  = s1_data_q[31:26];
    enc_word[31:17]  = s1_data_q[25:11];
    enc_word[15:9]   = s1_data_q[10:4];
    enc_word[7:5]    = s1_data_q[3:1];
    enc_word[3]      = s1_data_q[0];
    for (int i = 1; i < MW; i++) begin
      if (enc_word[i]) syn = syn ^ PARITY_BITS'(i);
    end
    if (s1_ecc_q) begin
      enc_word[1]  = syn[0];
      enc_word[2]  = syn[1];
      enc_word[4]  = syn[2];
      enc_word[8]  = syn[3];
      enc_word[16] = syn[4];
      enc_word[32] = syn[5];
      enc_word[0]  = ^enc_word[MW-1:1];
    end
  end

`ifdef ECC_ERR_INJ_EN
  logic       armed_q, armed_d;
  logic [1:0] mode_q, mode_d;
  logic [5:0] pos0_q, pos0_d;
  logic [5:0] pos1_q, pos1_d;
  logic       s2_inj_q, s2_inj_d;
  logic       arm_ok;
  logic [MW-1:0] m0, m1;

  assign arm_ok = inj_arm_i && (inj_mode_i == 2'b01 || inj_mode_i == 2'b10);

  always_comb begin
    m0 = '0;
    m1 = '0;
    if (pos0_q < 6'(MW)) m0 = MW'(1) << pos0_q;
    if (pos1_q < 6'(MW)) m1 = MW'(1) << pos1_q;
    flip_mask = '0;
    if (armed_q) begin
      unique case (1'b1)
        mode_q == 2'b01: flip_mask = m0;
        mode_q == 2'b10: flip_mask = m0 ^ m1;
        default:         flip_mask = '0;
      endcase
    end
  end

  // A fresh arm wins over the disarm caused by a simultaneous s2 load.
  always_comb begin
    armed_d  = armed_q;
    mode_d   = mode_q;
    pos0_d   = pos0_q;
    pos1_d   = pos1_q;
    s2_inj_d = s2_inj_q;
    if (s1_move) begin
      s2_inj_d = armed_q;
      armed_d  = 1'b0;
    end
    if (arm_ok) begin
      armed_d = 1'b1;
      mode_d  = inj_mode_i;
      pos0_d  = inj_pos0_i;
      pos1_d  = inj_pos1_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      mode_q   <= 2'b00;
      pos0_q   <= '0;
      pos1_q   <= '0;
      s2_inj_q <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      mode_q   <= mode_d;
      pos0_q   <= pos0_d;
      pos1_q   <= pos1_d;
      s2_inj_q <= s2_inj_d;
    end
  end

  assign inj_done_o = s2_drain && s2_inj_q;
`else
  assign flip_mask = '0;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_ecc_d   = s1_ecc_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    cnt_d      = cnt_q;
    if (s2_drain) s2_valid_d = 1'b0;
    if (s1_move) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b1;
      s2_data_d  = enc_word ^ flip_mask;
    end
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = bus.wr_data_i;
      s1_ecc_d   = ECC_en[0];
    end
    if (s2_drain && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_ecc_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_ecc_q   <= s1_ecc_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.wr_ready_o    = wr_ready;
  assign bus.mem_wr_en_o   = s2_drain;
  assign bus.mem_wr_data_o = s2_data_q;
  assign enc_count_o       = cnt_q;

endmodule

// File: tb/tb_ecc_wr_encoder.sv
// Directed bench for ecc_wr_encoder: encoding vectors, stall, reset, saturation.
// Injection cases run only when ECC_ERR_INJ_EN is defined.
module tb_ecc_wr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ecc_en;
  logic [31:0] enc_count;

  always #5 clk = ~clk;

  ecc_wr_encoder_if bus ();

  int checks = 0;
  int failures = 0;
  logic [38:0] wq[$];
  int done_cnt = 0;
  int rdy_low_cnt = 0;
  bit in_stream = 1'b0;

`ifdef ECC_ERR_INJ_EN
  logic       inj_arm;
  logic [1:0] inj_mode;
  logic [5:0] inj_pos0;
  logic [5:0] inj_pos1;
  logic       inj_done;
`endif

  ecc_wr_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ECC_en      (ecc_en),
    .bus         (bus.slave),
`ifdef ECC_ERR_INJ_EN
    .inj_arm_i   (inj_arm),
    .inj_mode_i  (inj_mode),
    .inj_pos0_i  (inj_pos0),
    .inj_pos1_i  (inj_pos1),
    .inj_done_o  (inj_done),
`endif
    .enc_count_o (enc_count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.mem_wr_en_o) begin
      wq.push_back(bus.mem_wr_data_o);
`ifdef ECC_ERR_INJ_EN
      if (inj_done) done_cnt++;
`endif
    end
    if (in_stream && !bus.wr_ready_o) begin
      rdy_low_cnt++;
      chk("rdy_low_needs_full", 64'(bus.mem_full_i), 64'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    bit ok = 1'b0;
    int n = 0;
    bus.wr_en_i   = 1'b1;
    bus.wr_data_i = d;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.wr_ready_o;
      tick();
      n++;
    end
    bus.wr_en_i = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_writes(input int n);
    int c = 0;
    while (wq.size() < n && c < 100) begin
      tick();
      c++;
    end
    chk("write_count", 64'(wq.size()), 64'(n));
  endtask

  task automatic chk_word(input string tag, input int idx,
                          input logic [38:0] exp);
    logic [38:0] got;
    got = '1;
    if (idx < wq.size()) got = wq[idx];
    chk(tag, 64'(got), 64'(exp));
  endtask

`ifdef ECC_ERR_INJ_EN
  task automatic arm(input logic [1:0] m, input logic [5:0] p0,
                     input logic [5:0] p1);
    inj_arm  = 1'b1;
    inj_mode = m;
    inj_pos0 = p0;
    inj_pos1 = p1;
    tick();
    inj_arm = 1'b0;
  endtask
`endif

  logic [31:0] s_data[8];
  logic [38:0] s_exp[8];
  int n0;
  int d0;

  initial begin
    s_data = '{32'h1, 32'h2, 32'h4, 32'h8,
               32'h8000_0000, 32'h3, 32'h10, 32'h800};
    s_exp  = '{39'h0F, 39'h33, 39'h55, 39'h96,
               39'h41_0000_0014, 39'h3C, 39'h303, 39'h3_0003};
    bus.wr_en_i    = 1'b0;
    bus.wr_data_i  = '0;
    bus.mem_full_i = 1'b0;
    ecc_en         = 32'h1;
`ifdef ECC_ERR_INJ_EN
    inj_arm  = 1'b0;
    inj_mode = 2'b00;
    inj_pos0 = '0;
    inj_pos1 = '0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(bus.wr_ready_o), 64'd1);
    chk("rst_wr_en", 64'(bus.mem_wr_en_o), 64'd0);
    chk("rst_data", 64'(bus.mem_wr_data_o), 64'd0);
    chk("rst_count", 64'(enc_count), 64'd0);

    // zero word, latency of two cycles
    tick();
    send(32'h0);
    @(negedge clk);
    chk("lat_n1_wr_en", 64'(bus.mem_wr_en_o), 64'd0);
    @(negedge clk);
    chk("lat_n2_wr_en", 64'(bus.mem_wr_en_o), 64'd1);
    chk("lat_n2_data", 64'(bus.mem_wr_data_o), 64'd0);
    tick();
    @(negedge clk);
    chk("count_one", 64'(enc_count), 64'd1);

    // ECC on then off; the snapshot rides with the word
    wq.delete();
    tick();
    send(32'h1);
    ecc_en = 32'h0;
    send(32'h1);
    ecc_en = 32'h1;
    wait_writes(2);
    chk_word("ecc_on_d1", 0, 39'h0F);
    chk_word("ecc_off_d1", 1, 39'h08);

    // back-to-back stream with a 5-cycle full stall
    wq.delete();
    rdy_low_cnt = 0;
    in_stream = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(s_data[i]);
      end
      begin
        repeat (3) tick();
        bus.mem_full_i = 1'b1;
        repeat (5) tick();
        bus.mem_full_i = 1'b0;
      end
    join
    wait_writes(8);
    in_stream = 1'b0;
    for (int i = 0; i < 8; i++) chk_word($sformatf("stream_%0d", i), i, s_exp[i]);
    chk("stream_rdy_dropped", 64'(rdy_low_cnt > 0), 64'd1);
    tick();
    chk("count_eleven", 64'(enc_count), 64'd11);

`ifdef ECC_ERR_INJ_EN
    wq.delete();
    d0 = done_cnt;
    arm(2'b01, 6'd3, 6'd0);
    send(32'h0);
    wait_writes(1);
    chk_word("inj_single", 0, 39'h08);
    chk("inj_done_once", 64'(done_cnt - d0), 64'd1);
    send(32'h1);
    wait_writes(2);
    chk_word("inj_after_clean", 1, 39'h0F);
    chk("inj_done_still_once", 64'(done_cnt - d0), 64'd1);
    arm(2'b10, 6'd5, 6'd9);
    send(32'h0);
    wait_writes(3);
    chk_word("inj_double", 2, 39'h220);
    arm(2'b01, 6'd45, 6'd0);
    send(32'h0);
    wait_writes(4);
    chk_word("inj_pos_oob", 3, 39'h0);
    arm(2'b10, 6'd7, 6'd7);
    send(32'h0);
    wait_writes(5);
    chk_word("inj_same_pos", 4, 39'h0);
    arm(2'b11, 6'd3, 6'd0);
    send(32'h0);
    wait_writes(6);
    chk_word("inj_mode11", 5, 39'h0);
`endif

    // reset with both stages occupied
    tick();
    bus.mem_full_i = 1'b1;
    send(32'h5);
    send(32'h6);
    n0 = wq.size();
    rst_n = 1'b0;
    tick();
    bus.mem_full_i = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rst_flush_writes", 64'(wq.size()), 64'(n0));
    chk("rst_flush_count", 64'(enc_count), 64'd0);
    chk("rst_flush_ready", 64'(bus.wr_ready_o), 64'd1);

    // counter saturation
    force dut.cnt_d = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.cnt_d;
    chk("sat_preload", 64'(enc_count), 64'hFFFF_FFFE);
    wq.delete();
    send(32'hA);
    send(32'hB);
    send(32'hC);
    wait_writes(3);
    repeat (2) tick();
    chk("sat_final", 64'(enc_count), 64'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
